// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the memory port arbiter: FSM state encodings,
// grant IDs and the default wait-state count.
package mem_port_arbiter_pkg;

    localparam int MEM_LAT_DEFAULT = 2;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_DM   = 2'd2
    } grant_e;

endpackage

// File: rtl/mem_port_arbiter_mem_lat_cnt.sv
// Loadable down-counter with a zero flag; generates memory wait states.
module mem_lat_cnt
    import mem_port_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    // Load wins over decrement; decrement saturates at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Define MEM_ARB_RR_EN for round-robin tie breaking; default is data over fetch.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEFAULT,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [31:0]   if_rdata,
    output logic          if_ack,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [3:0]    dm_be,
    input  logic [AW-1:0] dm_addr,
    input  logic [31:0]   dm_wdata,
    output logic [31:0]   dm_rdata,
    output logic          dm_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          busy,
    output logic [1:0]    dbg_state_o
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT - 1);

    state_e        state_q, state_d;
    grant_e        grant_q, grant_d;
    grant_e        pick;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic [31:0]   dm_rdata_q, dm_rdata_d;
    logic          cnt_load, cnt_dec, cnt_zero;

`ifdef MEM_ARB_RR_EN
    grant_e last_grant_q;

    always_comb begin
        pick = GNT_NONE;
        if (dm_req && if_req) begin
            pick = (last_grant_q == GNT_IF) ? GNT_DM : GNT_IF;
        end else if (dm_req) begin
            pick = GNT_DM;
        end else if (if_req) begin
            pick = GNT_IF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= GNT_IF;
        end else if ((state_q == ST_IDLE) && (pick != GNT_NONE)) begin
            last_grant_q <= pick;
        end
    end
`else
    always_comb begin
        pick = GNT_NONE;
        if (dm_req) begin
            pick = GNT_DM;
        end else if (if_req) begin
            pick = GNT_IF;
        end
    end
`endif

    mem_lat_cnt u_lat_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (LOAD_VAL),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= GNT_NONE;
            we_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick != GNT_NONE) begin
                    grant_d  = pick;
                    cnt_load = 1'b1;
                    state_d  = ST_ACCESS;
                    if (pick == GNT_DM) begin
                        we_d    = dm_we;
                        be_d    = dm_be;
                        addr_d  = dm_addr;
                        wdata_d = dm_wdata;
                    end else begin
                        we_d    = 1'b0;
                        be_d    = 4'hF;
                        addr_d  = if_addr;
                        wdata_d = '0;
                    end
                end
            end
            ST_ACCESS: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else begin
                    // Stores leave the requester's read data untouched.
                    if (!we_q) begin
                        if (grant_q == GNT_IF) begin
                            if_rdata_d = mem_rdata;
                        end else begin
                            dm_rdata_d = mem_rdata;
                        end
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                grant_d = GNT_NONE;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = GNT_NONE;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory bus is driven only from latched state and quiet outside ACCESS.
    assign mem_en      = (state_q == ST_ACCESS);
    assign mem_we      = mem_en & we_q;
    assign mem_be      = mem_en ? be_q : 4'h0;
    assign mem_addr    = mem_en ? addr_q : '0;
    assign mem_wdata   = mem_en ? wdata_q : '0;
    assign if_ack      = (state_q == ST_DONE) && (grant_q == GNT_IF);
    assign dm_ack      = (state_q == ST_DONE) && (grant_q == GNT_DM);
    assign if_rdata    = if_rdata_q;
    assign dm_rdata    = dm_rdata_q;
    assign busy        = (state_q != ST_IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 instance for the main flows,
// MEM_LAT=1 instance for back-to-back throughput.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [3:0]  dm_be;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_ack, dm_ack, mem_en, mem_we, busy;
    logic [3:0]  mem_be;
    logic [1:0]  dbg_state;

    logic        b_if_req, b_dm_req, b_dm_we;
    logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata, b_mem_rdata;
    logic [3:0]  b_dm_be;
    logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata;
    logic        b_if_ack, b_dm_ack, b_mem_en, b_mem_we, b_busy;
    logic [3:0]  b_mem_be;
    logic [1:0]  b_dbg_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(2), .AW(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy),
        .dbg_state_o(dbg_state)
    );

    mem_port_arbiter #(.MEM_LAT(1), .AW(32)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
        .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_be(b_dm_be), .dm_addr(b_dm_addr),
        .dm_wdata(b_dm_wdata), .dm_rdata(b_dm_rdata), .dm_ack(b_dm_ack),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy),
        .dbg_state_o(b_dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Advances until either ack appears (bounded), checking exclusivity each cycle.
    task automatic wait_ack(output logic got_if, output logic got_dm, output int cyc);
        got_if = 1'b0;
        got_dm = 1'b0;
        cyc    = 0;
        while (!got_if && !got_dm && cyc < 20) begin
            tick();
            cyc++;
            check("ack_exclusive", {31'b0, if_ack & dm_ack}, 32'd0);
            got_if = if_ack;
            got_dm = dm_ack;
        end
        check("ack_seen", {31'b0, got_if | got_dm}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       gi, gd;
        int         cyc;
        logic [2:0] exp_dm;

        rst = 1'b1;
        if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_be = 0;
        dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
        b_if_req = 0; b_if_addr = 0; b_dm_req = 0; b_dm_we = 0; b_dm_be = 0;
        b_dm_addr = 0; b_dm_wdata = 0; b_mem_rdata = 0;
        tick();
        tick();

        // Reset values
        check("rst_mem_en",    {31'b0, mem_en}, 32'd0);
        check("rst_mem_we",    {31'b0, mem_we}, 32'd0);
        check("rst_mem_be",    {28'b0, mem_be}, 32'd0);
        check("rst_mem_addr",  mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_if_ack",    {31'b0, if_ack}, 32'd0);
        check("rst_dm_ack",    {31'b0, dm_ack}, 32'd0);
        check("rst_if_rdata",  if_rdata, 32'd0);
        check("rst_dm_rdata",  dm_rdata, 32'd0);
        check("rst_busy",      {31'b0, busy}, 32'd0);
        rst = 1'b0;
        tick();

        // Single fetch
        if_req = 1; if_addr = 32'h40; mem_rdata = 32'h00A00093;
        check("f_c0_busy", {31'b0, busy}, 32'd0);
        for (int c = 1; c <= 2; c++) begin
            tick();
            check("f_mem_en",   {31'b0, mem_en}, 32'd1);
            check("f_mem_addr", mem_addr, 32'h40);
            check("f_mem_we",   {31'b0, mem_we}, 32'd0);
            check("f_mem_be",   {28'b0, mem_be}, 32'hF);
            check("f_if_ack",   {31'b0, if_ack}, 32'd0);
            check("f_dm_ack",   {31'b0, dm_ack}, 32'd0);
        end
        tick();
        check("f_ack",    {31'b0, if_ack}, 32'd1);
        check("f_rdata",  if_rdata, 32'h00A00093);
        check("f_dm_ack", {31'b0, dm_ack}, 32'd0);
        check("f_en_off", {31'b0, mem_en}, 32'd0);
        if_req = 0;
        tick();
        check("f_idle_busy", {31'b0, busy}, 32'd0);
        check("f_idle_ack",  {31'b0, if_ack}, 32'd0);

        // Store, with inputs perturbed mid-access
        dm_req = 1; dm_we = 1; dm_be = 4'b0011; dm_addr = 32'h100;
        dm_wdata = 32'hDEADBEEF; mem_rdata = 32'h12345678;
        for (int c = 1; c <= 2; c++) begin
            tick();
            check("s_mem_en",    {31'b0, mem_en}, 32'd1);
            check("s_mem_we",    {31'b0, mem_we}, 32'd1);
            check("s_mem_be",    {28'b0, mem_be}, 32'h3);
            check("s_mem_addr",  mem_addr, 32'h100);
            check("s_mem_wdata", mem_wdata, 32'hDEADBEEF);
            dm_addr = 0; dm_wdata = 0; dm_be = 4'hF;
        end
        tick();
        check("s_dm_ack",   {31'b0, dm_ack}, 32'd1);
        check("s_if_ack",   {31'b0, if_ack}, 32'd0);
        check("s_dm_rdata", dm_rdata, 32'd0);
        check("s_if_rdata", if_rdata, 32'h00A00093);
        dm_req = 0; dm_we = 0;
        tick();

        // Simultaneous requests from reset: data first, fetch at cycle 7
        do_reset();
        if_req = 1; if_addr = 32'h200;
        dm_req = 1; dm_we = 0; dm_be = 4'hF; dm_addr = 32'h300;
        mem_rdata = 32'hCAFE0001;
        wait_ack(gi, gd, cyc);
        check("tie_dm_first", {31'b0, gd}, 32'd1);
        check("tie_dm_lat",   cyc, 32'd3);
        check("tie_dm_rdata", dm_rdata, 32'hCAFE0001);
        dm_req = 0; mem_rdata = 32'hCAFE0002;
        wait_ack(gi, gd, cyc);
        check("tie_if_second", {31'b0, gi}, 32'd1);
        check("tie_if_lat",    cyc, 32'd4);
        check("tie_if_rdata",  if_rdata, 32'hCAFE0002);
        if_req = 0;
        tick();

        // Three consecutive ties: winner drops and re-raises in the next IDLE
`ifdef MEM_ARB_RR_EN
        exp_dm = 3'b101;
`else
        exp_dm = 3'b111;
`endif
        do_reset();
        if_req = 1; if_addr = 32'h400;
        dm_req = 1; dm_we = 0; dm_addr = 32'h500;
        for (int k = 0; k < 3; k++) begin
            wait_ack(gi, gd, cyc);
            check("rr_winner_dm", {31'b0, gd}, {31'b0, exp_dm[k]});
            check("rr_lat", cyc, 32'd3);
            if (gd) dm_req = 0;
            else    if_req = 0;
            tick();
            if (k < 2) begin
                if (gd) dm_req = 1;
                else    if_req = 1;
            end
        end
        wait_ack(gi, gd, cyc);
        check("rr_tail_if", {31'b0, gi}, 32'd1);
        check("rr_tail_lat", cyc, 32'd3);
        if_req = 0;
        tick();

        // Reset during the second ACCESS cycle
        if_req = 1; if_addr = 32'h80; mem_rdata = 32'hBAD0BAD0;
        tick();
        check("r_en_before", {31'b0, mem_en}, 32'd1);
        tick();
        rst = 1'b1;
        #1;
        check("r_en_async", {31'b0, mem_en}, 32'd0);
        check("r_busy",     {31'b0, busy}, 32'd0);
        check("r_if_ack",   {31'b0, if_ack}, 32'd0);
        if_req = 0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("r_no_if_ack", {31'b0, if_ack}, 32'd0);
            check("r_no_dm_ack", {31'b0, dm_ack}, 32'd0);
            check("r_idle",      {31'b0, busy}, 32'd0);
        end
        if_req = 1; if_addr = 32'h84; mem_rdata = 32'h00000013;
        tick();
        check("r2_mem_addr", mem_addr, 32'h84);
        check("r2_mem_en",   {31'b0, mem_en}, 32'd1);
        tick();
        tick();
        check("r2_ack",   {31'b0, if_ack}, 32'd1);
        check("r2_rdata", if_rdata, 32'h00000013);
        if_req = 0;
        tick();

        // MEM_LAT=1 back-to-back fetch, request dropped mid-ACCESS
        b_if_req = 1; b_if_addr = 32'h600;
        for (int c = 1; c <= 8; c++) begin
            b_mem_rdata = 32'h1000 + c;
            tick();
            check("b_if_ack", {31'b0, b_if_ack}, {31'b0, (c % 3) == 2});
            check("b_dm_ack", {31'b0, b_dm_ack}, 32'd0);
            if ((c % 3) == 2) check("b_if_rdata", b_if_rdata, 32'h1000 + c);
            if (c == 7) b_if_req = 0;
        end
        tick();
        check("b_after_ack",  {31'b0, b_if_ack}, 32'd0);
        check("b_after_busy", {31'b0, b_busy}, 32'd0);
        tick();
        check("b_stays_idle", {31'b0, b_busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
